// File: rtl/bitstream_byte_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_byte_feeder_pkg
//  Description : Shared constants and helpers for the bitstream byte feeder.
//                Holds the emulation-prevention byte value, the zero-run
//                tracker encoding and the next-state helper for it.
//  Revision    : 1.0 - initial release
// ============================================================================
package bitstream_byte_feeder_pkg;

    localparam logic [7:0] EPB_BYTE       = 8'h03;
    localparam int         ZERO_RUN_MAX   = 2;
    localparam int         BYTES_PER_WORD = 4;

    // Zero-run tracker states. The encoding equals the number of
    // consecutive 0x00 payload bytes seen, capped at ZERO_RUN_MAX.
    localparam logic [1:0] ZR_Z0 = 2'd0;
    localparam logic [1:0] ZR_Z1 = 2'd1;
    localparam logic [1:0] ZR_Z2 = 2'(ZERO_RUN_MAX);

    // Zero-run state after a byte has been kept as payload.
    function automatic logic [1:0] next_zero_run(input logic [1:0] zr,
                                                 input logic [7:0] b);
        logic [1:0] nxt;
        nxt = ZR_Z0;
        if (b == 8'h00) begin
            case (zr)
                ZR_Z0:   nxt = ZR_Z1;
                ZR_Z1:   nxt = ZR_Z2;
                default: nxt = ZR_Z2;
            endcase
        end
        return nxt;
    endfunction

endpackage : bitstream_byte_feeder_pkg
`default_nettype wire

// File: rtl/bitstream_byte_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Small synchronous FIFO with a registered head output.
//                head shows the oldest entry (0 when empty) and is updated on
//                the same edge as the push/pop that changes it, so a byte
//                written into an empty FIFO is visible on the next cycle.
//  Ports       : clk, reset (async, active-high), clear (sync drop-all),
//                push/push_data, pop, head, empty, full, level
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_next_rd;
    logic [AW:0]      w_next_count;
    logic [WIDTH-1:0] w_next_head;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign level = r_count;
    assign head  = r_head;

    assign w_push    = push && !full;
    assign w_pop     = pop && !empty;
    assign w_next_rd = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + (AW+1)'(1);
            2'b01:   w_next_count = r_count - (AW+1)'(1);
            default: w_next_count = r_count;
        endcase
    end

    // Head after this edge: if the new head slot is the one being written
    // now, bypass the array so the byte does not lag a cycle.
    always_comb begin
        w_next_head = '0;
        if (w_next_count != '0) begin
            if (w_push && (w_next_rd == r_wr_ptr)) begin
                w_next_head = push_data;
            end else begin
                w_next_head = r_mem[w_next_rd];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_next_rd;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_count <= w_next_count;
            r_head  <= w_next_head;
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/bitstream_byte_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_byte_feeder
//  Description : Unpacks 32-bit bitstream words MSB byte first, strips
//                emulation-prevention bytes (00 00 03 -> 00 00) and buffers
//                the payload in a byte FIFO for the bin decoder.
//  Ports       : clk, reset (async, active-high), flush (sync slice clear),
//                word_in/word_valid/word_ready (word handshake),
//                request_byte (pop), data/data_valid (head byte),
//                underflow (sticky), fill_level, epb_count (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module bitstream_byte_feeder
    import bitstream_byte_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [31:0]                   word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic                          request_byte,
    output logic [7:0]                    data,
    output logic                          data_valid,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]              epb_count
);

    localparam logic [1:0] c_LAST_LANE = 2'(BYTES_PER_WORD - 1);

    // Word register state
    logic [31:0]      r_word;
    logic             r_full;
    logic [1:0]       r_lane;
    // EPB filter state
    logic [1:0]       r_zero_run;
    logic             r_underflow;
    logic [CNT_W-1:0] r_epb_count;

    logic [7:0]       w_byte;
    logic             w_drop;
    logic             w_consume;
    logic             w_push;
    logic             w_pop;
    logic             w_accept;
    logic             w_fifo_empty;
    logic             w_fifo_full;

    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = r_word[31:24];
            2'd1:    w_byte = r_word[23:16];
            2'd2:    w_byte = r_word[15:8];
            default: w_byte = r_word[7:0];
        endcase
    end

    assign w_drop     = (r_zero_run == ZR_Z2) && (w_byte == EPB_BYTE);
    // A dropped byte never needs FIFO space, so it proceeds even when full.
    assign w_consume  = r_full && (!w_fifo_full || w_drop);
    assign w_push     = w_consume && !w_drop && !flush;
    assign w_pop      = request_byte && !w_fifo_empty;
    assign word_ready = !r_full || ((r_lane == c_LAST_LANE) && w_consume);
    assign w_accept   = word_valid && word_ready;

    assign data_valid = !w_fifo_empty;
    assign underflow  = r_underflow;
    assign epb_count  = r_epb_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word      <= '0;
            r_full      <= 1'b0;
            r_lane      <= '0;
            r_zero_run  <= ZR_Z0;
            r_underflow <= 1'b0;
            r_epb_count <= '0;
        end else if (flush) begin
            r_full      <= 1'b0;
            r_lane      <= '0;
            r_zero_run  <= ZR_Z0;
            r_underflow <= 1'b0;
        end else begin
            if (request_byte && w_fifo_empty) begin
                r_underflow <= 1'b1;
            end

            if (w_consume) begin
                if (w_drop) begin
                    r_zero_run <= ZR_Z0;
                    if (r_epb_count != '1) begin
                        r_epb_count <= r_epb_count + CNT_W'(1);
                    end
                end else begin
                    r_zero_run <= next_zero_run(r_zero_run, w_byte);
                end
            end

            // An accept on the last-lane cycle reloads the register, so it
            // takes priority over the lane advance / empty transition.
            if (w_accept) begin
                r_word <= word_in;
                r_full <= 1'b1;
                r_lane <= '0;
            end else if (w_consume) begin
                r_lane <= r_lane + 2'd1;
                if (r_lane == c_LAST_LANE) begin
                    r_full <= 1'b0;
                end
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_byte_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (w_push),
        .push_data (w_byte),
        .pop       (w_pop),
        .head      (data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full),
        .level     (fill_level)
    );

endmodule : bitstream_byte_feeder
`default_nettype wire
